spe_accumulator: RTL and testbench

Summing PE: the receiving end of the partial-sum packets that PPEs emit.
- Collects one partial sum per filter row (FILTER_SIZE rows) for the current output pixel and adds them.
- Integrates the total into a per-pixel membrane potential and thresholds it.
- Sends a spike packet to the output memory node.
- Sits between the PPE array and the output memory on the packet network, using the same 30-bit packet format.

---
 rtl/spe_accumulator.sv | 149 ++++++++++++++
 tb/tb_spe_accumulator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spe_accumulator.sv
// Summing PE: gathers one partial sum per filter row for the current output pixel,
// integrates the total into that pixel's membrane potential and emits a spike packet.
module spe_accumulator #(
    parameter int         FILTER_SIZE = 5,
    parameter int         OUTPUT_DIM  = 21,
    parameter logic [3:0] MY_ADDR     = 4'd5,
    parameter logic [3:0] OUT_MEM_ID  = 4'd11,
    parameter int         THRESHOLD   = 64,
    parameter int         VWIDTH      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [29:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        timestep_done,
    output logic        err_dup,
    output logic        err_misroute
);

    localparam int PIXELS = OUTPUT_DIM * OUTPUT_DIM;
    localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int ACC_W  = 17;
    localparam int SUM_W  = VWIDTH + 2;

    localparam logic signed [SUM_W-1:0] V_MAX = (SUM_W'(1) <<< (VWIDTH - 1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] V_MIN = -(SUM_W'(1) <<< (VWIDTH - 1));
    localparam logic signed [SUM_W-1:0] V_THR = SUM_W'(THRESHOLD);

    typedef enum logic [1:0] {
        COLLECT,
        FIRE,
        SEND
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic signed [ACC_W-1:0]  acc;
    logic [FILTER_SIZE-1:0]   row_mask;
    logic [PIX_W-1:0]         pix;
    logic signed [VWIDTH-1:0] v_mem [PIXELS];

    logic [3:0]               pkt_dest;
    logic                     pkt_op;
    logic [2:0]               pkt_row;
    logic signed [13:0]       pkt_psum;
    logic [7:0]               mask_ext;
    logic [FILTER_SIZE-1:0]   row_bit;
    logic [FILTER_SIZE-1:0]   mask_next;
    logic                     accept;
    logic                     misroute;
    logic                     row_bad;
    logic                     row_accept;
    logic                     row_complete;
    logic                     handshake;

    logic signed [SUM_W-1:0]  vsum_raw;
    logic signed [SUM_W-1:0]  vsum_sat;
    logic                     spike;
    logic signed [VWIDTH-1:0] v_new;

    assign pkt_dest = in_data[29:26];
    assign pkt_op   = in_data[25];
    assign pkt_row  = in_data[16:14];
    assign pkt_psum = in_data[13:0];

    assign in_ready  = (state == COLLECT) && !reset;
    assign out_valid = (state == SEND);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    // Row index is 3 bits wide, so the mask is padded to 8 entries for safe lookup.
    assign mask_ext     = 8'(row_mask);
    assign row_bit      = FILTER_SIZE'(8'b1 << pkt_row);
    assign mask_next    = row_mask | row_bit;
    assign misroute     = (pkt_dest != MY_ADDR) || pkt_op;
    assign row_bad      = (int'(pkt_row) >= FILTER_SIZE) || mask_ext[pkt_row];
    assign row_accept   = accept && !misroute && !row_bad;
    assign row_complete = row_accept && (mask_next == {FILTER_SIZE{1'b1}});

    always_comb begin
        vsum_raw = SUM_W'(v_mem[pix]) + SUM_W'(acc);
        vsum_sat = vsum_raw;
        if (vsum_raw > V_MAX) begin
            vsum_sat = V_MAX;
        end else if (vsum_raw < V_MIN) begin
            vsum_sat = V_MIN;
        end
        spike = (vsum_sat >= V_THR);
        v_new = spike ? '0 : vsum_sat[VWIDTH-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (row_complete) state_next = FIRE;
            FIRE:    state_next = SEND;
            SEND:    if (out_ready) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= COLLECT;
            acc           <= '0;
            row_mask      <= '0;
            pix           <= '0;
            out_data      <= '0;
            timestep_done <= 1'b0;
            err_dup       <= 1'b0;
            err_misroute  <= 1'b0;
            for (int i = 0; i < PIXELS; i++) begin
                v_mem[i] <= '0;
            end
        end else begin
            state         <= state_next;
            err_misroute  <= accept && misroute;
            err_dup       <= accept && !misroute && row_bad;
            timestep_done <= 1'b0;

            if (row_accept) begin
                acc      <= acc + ACC_W'(pkt_psum);
                row_mask <= mask_next;
            end

            if (state == FIRE) begin
                v_mem[pix] <= v_new;
                out_data   <= {OUT_MEM_ID, spike, 16'b0, 9'(pix)};
            end

            // Pixel bookkeeping advances only once the spike packet has left.
            if (handshake) begin
                acc      <= '0;
                row_mask <= '0;
                if (pix == PIX_W'(PIXELS - 1)) begin
                    pix           <= '0;
                    timestep_done <= 1'b1;
                end else begin
                    pix <= pix + PIX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_spe_accumulator.sv
// Directed and randomized checks of spe_accumulator against an arithmetic model of
// per-pixel membrane integration, saturation, thresholding and pixel sequencing.
module tb_spe_accumulator;

    localparam int         FS     = 5;
    localparam int         DIM    = 2;
    localparam int         PIXELS = DIM * DIM;
    localparam int         THRESH = 64;
    localparam logic [3:0] MY     = 4'd5;
    localparam logic [3:0] OMEM   = 4'd11;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        timestep_done;
    logic        err_dup;
    logic        err_misroute;

    int vectors     = 0;
    int miscompares = 0;

    int model_v [PIXELS];
    int model_pix;
    int psum_q  [FS];
    int order_q [FS];

    spe_accumulator #(
        .FILTER_SIZE(FS),
        .OUTPUT_DIM (DIM),
        .MY_ADDR    (MY),
        .OUT_MEM_ID (OMEM),
        .THRESHOLD  (THRESH),
        .VWIDTH     (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .timestep_done(timestep_done),
        .err_dup      (err_dup),
        .err_misroute (err_misroute)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] dest, input logic op, input int row, input int psum);
        in_data  = {dest, op, 8'b0, 3'(row), 14'(psum)};
        in_valid = 1'b1;
        checkOutput("in_ready_collect", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [29:0] modelFire(input int acc);
        int vsum;
        bit spike;
        vsum = model_v[model_pix] + acc;
        if (vsum > 32767) vsum = 32767;
        if (vsum < -32768) vsum = -32768;
        spike = (vsum >= THRESH);
        model_v[model_pix] = spike ? 0 : vsum;
        return {OMEM, spike, 16'b0, 9'(model_pix)};
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < PIXELS; i++) model_v[i] = 0;
        model_pix = 0;
    endfunction

    task automatic finishPixel(input int acc, input int stall, input string tag);
        logic [29:0] exp_pkt;
        bit last;
        checkOutput({tag, ":fire_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ":fire_ready"}, 32'(in_ready), 32'd0);
        exp_pkt = modelFire(acc);
        last = (model_pix == PIXELS - 1);
        @(posedge clk);
        #1;
        checkOutput({tag, ":send_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, ":send_data"}, 32'(out_data), 32'(exp_pkt));
        checkOutput({tag, ":send_ready"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, ":stall_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, ":stall_data"}, 32'(out_data), 32'(exp_pkt));
            checkOutput({tag, ":stall_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, ":post_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ":tdone"}, 32'(timestep_done), 32'(last));
        checkOutput({tag, ":post_ready"}, 32'(in_ready), 32'd1);
        model_pix = (model_pix + 1) % PIXELS;
        @(posedge clk);
        #1;
        checkOutput({tag, ":tdone_end"}, 32'(timestep_done), 32'd0);
    endtask

    task automatic runPixel(input int stall, input string tag);
        int acc;
        acc = 0;
        for (int i = 0; i < FS; i++) begin
            applyStimulus(MY, 1'b0, order_q[i], psum_q[i]);
            acc += psum_q[i];
            checkOutput({tag, ":err_dup"}, 32'(err_dup), 32'd0);
            checkOutput({tag, ":err_mis"}, 32'(err_misroute), 32'd0);
        end
        finishPixel(acc, stall, tag);
    endtask

    function automatic void setUniform(input int val);
        for (int i = 0; i < FS; i++) begin
            psum_q[i]  = val;
            order_q[i] = i;
        end
    endfunction

    function automatic void setRandom();
        for (int i = 0; i < FS; i++) begin
            psum_q[i]  = int'($urandom_range(16383, 0)) - 8192;
            order_q[i] = i;
        end
        for (int i = FS - 1; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = order_q[i];
            order_q[i] = order_q[j];
            order_q[j] = t;
        end
    endfunction

    task automatic fillRandom(input string tag);
        setRandom();
        runPixel(int'($urandom_range(2, 0)), tag);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_tdone", 32'(timestep_done), 32'd0);
        checkOutput("rst_err_dup", 32'(err_dup), 32'd0);
        checkOutput("rst_err_mis", 32'(err_misroute), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic fire on pixel 0: 10+20+5+15+20 = 70 crosses the threshold.
        psum_q  = '{10, 20, 5, 15, 20};
        order_q = '{0, 1, 2, 3, 4};
        runPixel(0, "fire");

        // Pixel 0 integrates 30, then 60, then 65 across timesteps.
        for (int p = 1; p < PIXELS; p++) fillRandom("fill_a");
        setUniform(6);
        runPixel(0, "sub_30");
        for (int p = 1; p < PIXELS; p++) fillRandom("fill_b");
        setUniform(6);
        runPixel(1, "sub_60");
        for (int p = 1; p < PIXELS; p++) fillRandom("fill_c");
        setUniform(1);
        runPixel(0, "sub_65");

        // Out-of-order rows with one duplicate.
        applyStimulus(MY, 1'b0, 3, 1);
        applyStimulus(MY, 1'b0, 1, 1);
        checkOutput("dup_none_yet", 32'(err_dup), 32'd0);
        applyStimulus(MY, 1'b0, 1, 1);
        checkOutput("dup_pulse", 32'(err_dup), 32'd1);
        applyStimulus(MY, 1'b0, 0, 1);
        checkOutput("dup_pulse_end", 32'(err_dup), 32'd0);
        applyStimulus(MY, 1'b0, 4, 1);
        checkOutput("dup_no_fire", 32'(out_valid), 32'd0);
        checkOutput("dup_still_ready", 32'(in_ready), 32'd1);
        applyStimulus(MY, 1'b0, 2, 1);
        finishPixel(5, 0, "dup");

        // Misrouted packets and bad row index leave accumulation untouched.
        applyStimulus(4'd7, 1'b0, 0, 100);
        checkOutput("mis_dest", 32'(err_misroute), 32'd1);
        checkOutput("mis_dest_dup", 32'(err_dup), 32'd0);
        applyStimulus(MY, 1'b1, 1, 100);
        checkOutput("mis_opcode", 32'(err_misroute), 32'd1);
        applyStimulus(MY, 1'b0, 6, 100);
        checkOutput("badrow_mis", 32'(err_misroute), 32'd0);
        checkOutput("badrow_dup", 32'(err_dup), 32'd1);
        setRandom();
        runPixel(3, "backpressure");

        // Reset while a packet is waiting in SEND.
        setUniform(3);
        for (int i = 0; i < FS; i++) applyStimulus(MY, 1'b0, order_q[i], psum_q[i]);
        @(posedge clk);
        #1;
        checkOutput("rsend_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rsend_drop", 32'(out_valid), 32'd0);
        checkOutput("rsend_data", 32'(out_data), 32'd0);
        checkOutput("rsend_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("rsend_rel_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Negative saturation, cleared potentials, wrap, then positive recovery.
        setUniform(-8192);
        runPixel(0, "sat_neg");
        for (int p = 1; p < PIXELS; p++) begin
            setUniform(12);
            runPixel(0, "cleared");
        end
        setUniform(8191);
        runPixel(0, "sat_recover");

        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(3, 0) == 0) begin
                applyStimulus(4'((MY + 4'd1 + 4'($urandom_range(14, 0)))), 1'b0,
                              int'($urandom_range(4, 0)), 500);
                checkOutput("rand_mis", 32'(err_misroute), 32'd1);
            end
            fillRandom("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
